zoom_out_scheduler: RTL

//  Command-driven sequencer for the 2x2 block-average downscaler (media_de_blocos).

---
 rtl/zoom_pkg.sv | 25 ++
 rtl/frame_addr_gen.sv | 36 +++
 rtl/zoom_out_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/zoom_pkg.sv
// Shared types and helpers for the 2x2 downscale job sequencer.
// Holds the width limit, FSM encoding and the job legality rule.
package zoom_pkg;

    localparam int LARGURA_MAX = 640;
    localparam int DIM_W       = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_STREAM,
        S_DRAIN,
        S_ABORT
    } state_t;

    function automatic logic job_legal(
        input logic [DIM_W-1:0] w,
        input logic [DIM_W-1:0] h,
        input int               max_w
    );
        return (w >= 10'd2) && (h >= 10'd2) &&
               !w[0] && !h[0] && (int'(w) <= max_w);
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Base plus running count address generator.
// o_term flags that the count reaches i_limit after this cycle.
module frame_addr_gen #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_limit,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_term
);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + ADDR_W'(i_inc);
    assign o_addr    = r_base + r_cnt;
    assign o_term    = (w_cnt_nxt == i_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/zoom_out_scheduler.sv
// Job sequencer for the 2x2 block-average downscaler: launches the job,
// streams source pixels one per cycle and writes averaged pixels back.
module zoom_out_scheduler #(
    parameter int ADDR_W      = 20,
    parameter int LARGURA_MAX = zoom_pkg::LARGURA_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_width,
    input  logic [9:0]        cmd_height,
    input  logic [ADDR_W-1:0] cmd_src_base,
    input  logic [ADDR_W-1:0] cmd_dst_base,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic              ds_resetn,
    output logic              ds_start,
    output logic [9:0]        ds_largura,
    output logic [9:0]        ds_altura,
    output logic [7:0]        ds_pixel,
    input  logic              ds_pixel_ready,
    input  logic              ds_out_valid,
    input  logic [7:0]        ds_out_pixel,
    input  logic              ds_done
);
    import zoom_pkg::*;

    state_t            r_state;
    logic [9:0]        r_w;
    logic [9:0]        r_h;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_m;
    logic              r_rd_en;
    logic              r_ds_start;
    logic              r_done;
    logic              r_err;
    logic              r_ds_resetn;
    logic              r_abort_cnt;

    logic              w_accept;
    logic              w_legal;
    logic              w_load;
    logic              w_wr_act;
    logic              w_rd_term;
    logic              w_wr_term;
    logic [19:0]       w_n;
    logic [19:0]       w_m;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_legal  = job_legal(cmd_width, cmd_height, LARGURA_MAX);
    assign w_load   = w_accept && w_legal;
    assign w_n      = 20'(cmd_width) * 20'(cmd_height);
    assign w_m      = 20'(cmd_width[9:1]) * 20'(cmd_height[9:1]);
    assign w_wr_act = (r_state == S_STREAM) || (r_state == S_DRAIN);

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign mem_rd_en   = r_rd_en;
    assign mem_wr_en   = w_wr_act && ds_out_valid;
    assign mem_wr_data = mem_wr_en ? ds_out_pixel : '0;
    assign ds_start    = r_ds_start;
    assign ds_largura  = r_w;
    assign ds_altura   = r_h;
    assign ds_pixel    = mem_rd_data;
    // Reset reaches the downscaler in the same cycle it is raised
    assign ds_resetn   = r_ds_resetn && !reset;

    frame_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_inc   (r_rd_en),
        .i_base  (cmd_src_base),
        .i_limit (r_n),
        .o_addr  (mem_rd_addr),
        .o_term  (w_rd_term)
    );

    frame_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_inc   (mem_wr_en),
        .i_base  (cmd_dst_base),
        .i_limit (r_m),
        .o_addr  (mem_wr_addr),
        .o_term  (w_wr_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_h         <= '0;
            r_n         <= '0;
            r_m         <= '0;
            r_rd_en     <= 1'b0;
            r_ds_start  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ds_resetn <= 1'b0;
            r_abort_cnt <= 1'b0;
        end else begin
            r_ds_start <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_ds_resetn <= 1'b1;
                    if (w_load) begin
                        r_w        <= cmd_width;
                        r_h        <= cmd_height;
                        r_n        <= ADDR_W'(w_n);
                        r_m        <= ADDR_W'(w_m);
                        r_ds_start <= 1'b1;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end else if (w_accept) begin
                        r_err <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (abort) begin
                        r_state     <= S_ABORT;
                        r_rd_en     <= 1'b0;
                        r_ds_resetn <= 1'b0;
                        r_abort_cnt <= 1'b0;
                    end else begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM, S_DRAIN: begin
                    if (abort || !ds_pixel_ready) begin
                        r_state     <= S_ABORT;
                        r_rd_en     <= 1'b0;
                        r_ds_resetn <= 1'b0;
                        r_abort_cnt <= 1'b0;
                        r_err       <= !abort;
                    end else if (r_state == S_STREAM) begin
                        if (w_rd_term) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_DRAIN;
                        end
                    end else if (ds_done) begin
                        // w_wr_term already counts a write taken this cycle
                        r_done  <= w_wr_term;
                        r_err   <= !w_wr_term;
                        r_state <= S_IDLE;
                    end
                end
                S_ABORT: begin
                    if (r_abort_cnt) begin
                        r_ds_resetn <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_abort_cnt <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
